intcon_ctrl: RTL and testbench

Interrupt controller for the PIC16F84A core: the consumer end of the tmr0 overflow request (t0if), plus RB0/INT edge, RB7:4 change and EEPROM-write-complete sources. Holds the INTCON register and latches flags. Runs a request/acknowledge handshake with the CPU sequencer: request, GIE clear on vector entry, GIE restore on RETFIE. Also drives a SLEEP wake-up line.

---
 rtl/pic_intcon_pkg.sv | 33 +++
 rtl/pin_sync.sv | 40 ++++
 rtl/intcon_ctrl.sv | 151 +++++++++++++++
 tb/tb_intcon_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_intcon_pkg.sv
// Shared definitions for the PIC16F84A interrupt controller.
//   - INTCON bit positions (GIE..RBIF)
//   - FSM state encoding for the CPU request/acknowledge handshake
//   - interrupt vector address used by the CPU sequencer
//   - helper computing the combined pending condition
package pic_intcon_pkg;

  localparam int unsigned GIE_BIT  = 7;
  localparam int unsigned EEIE_BIT = 6;
  localparam int unsigned T0IE_BIT = 5;
  localparam int unsigned INTE_BIT = 4;
  localparam int unsigned RBIE_BIT = 3;
  localparam int unsigned T0IF_BIT = 2;
  localparam int unsigned INTF_BIT = 1;
  localparam int unsigned RBIF_BIT = 0;

  localparam logic [12:0] INT_VECTOR = 13'h0004;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_ISR  = 2'b10
  } intcon_state_t;

  // Any enabled source flagged; GIE is deliberately not part of this.
  function automatic logic calc_pend(input logic [7:0] intcon, input logic ee_pend);
    calc_pend = (intcon[T0IE_BIT] & intcon[T0IF_BIT]) |
                (intcon[INTE_BIT] & intcon[INTF_BIT]) |
                (intcon[RBIE_BIT] & intcon[RBIF_BIT]) |
                (intcon[EEIE_BIT] & ee_pend);
  endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchronizer for an asynchronous pin, followed by an edge
// detector against a registered copy of the synchronized level.
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset (chain and history to 0)
//   pin    in   asynchronous input
//   sync   out  synchronized level (last stage of the chain)
//   rise   out  sync is 1, previous sample was 0
//   fall   out  sync is 0, previous sample was 1
module pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  // Edge outputs are decoded from two registers so a pin change becomes
  // usable on edge SYNC_STAGES and lands in a flag on edge SYNC_STAGES+1.
  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/intcon_ctrl.sv
// Interrupt controller for the PIC16F84A core. Holds INTCON, latches the
// tmr0 overflow, RB0/INT edge and RB7:4 change flags, keeps the EEPROM
// write-complete pending bit, and runs the request/acknowledge handshake
// with the CPU sequencer (GIE cleared on vector entry, restored on RETFIE).
// Ports:
//   oscIn         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   t0if          in   tmr0 overflow level (same clock domain)
//   eeif          in   EEPROM write-complete pulse
//   rb0_pin       in   RB0/INT pin (asynchronous)
//   intedg        in   1 = rising edge on RB0 sets INTF, 0 = falling
//   rb_hi_pin     in   RB7:4 pins (asynchronous)
//   rb_hi_tris    in   TRISB7:4, only input bits are compared
//   portb_rd      in   PORTB read, loads RB7:4 snapshot
//   intcon_we     in   INTCON write strobe
//   intcon_wdata  in   INTCON write data
//   intcon_rdata  out  current INTCON
//   irq_req       out  registered interrupt request
//   irq_ack       in   CPU takes the vector this cycle
//   retfie        in   CPU executes RETFIE this cycle
//   wake          out  registered "enabled flag set", ignores GIE
module intcon_ctrl
  import pic_intcon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  INTCON_RST  = 8'h00
) (
  input  logic       oscIn,
  input  logic       reset,
  input  logic       t0if,
  input  logic       eeif,
  input  logic       rb0_pin,
  input  logic       intedg,
  input  logic [3:0] rb_hi_pin,
  input  logic [3:0] rb_hi_tris,
  input  logic       portb_rd,
  input  logic       intcon_we,
  input  logic [7:0] intcon_wdata,
  output logic [7:0] intcon_rdata,
  output logic       irq_req,
  input  logic       irq_ack,
  input  logic       retfie,
  output logic       wake
);

  intcon_state_t state, state_next;
  logic [7:0]    intcon, intcon_next;
  logic          t0if_q;
  logic          ee_pend;
  logic [3:0]    rb_snap;
  logic          pend;
  logic          ack_take;

  logic          t0_set, int_set, rb_set;
  logic          rb0_sync, rb0_rise, rb0_fall;
  logic [3:0]    rb_sync, rb_rise, rb_fall;
  logic          unused_sig;

  // ---------------------------------------------------------------- sources
  assign t0_set = t0if & ~t0if_q;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rb0_sync (
    .clk   (oscIn),
    .rst_n (reset),
    .pin   (rb0_pin),
    .sync  (rb0_sync),
    .rise  (rb0_rise),
    .fall  (rb0_fall)
  );

  // Polarity selects between edge pulses, so toggling intedg on a steady
  // pin cannot fabricate an edge.
  assign int_set = intedg ? rb0_rise : rb0_fall;

  for (genvar i = 0; i < 4; i++) begin : g_rb_sync
    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rb_sync (
      .clk   (oscIn),
      .rst_n (reset),
      .pin   (rb_hi_pin[i]),
      .sync  (rb_sync[i]),
      .rise  (rb_rise[i]),
      .fall  (rb_fall[i])
    );
  end

  assign rb_set     = |((rb_sync ^ rb_snap) & rb_hi_tris);
  assign unused_sig = ^{rb0_sync, rb_rise, rb_fall};

  assign pend = calc_pend(intcon, ee_pend);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge oscIn or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ack_take   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (intcon[GIE_BIT] && pend) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (irq_ack) begin
          ack_take   = 1'b1;
          state_next = ST_ISR;
        end else if (!(intcon[GIE_BIT] && pend)) begin
          state_next = ST_IDLE;
        end
      end
      ST_ISR: begin
        if (retfie || (intcon_we && intcon_wdata[GIE_BIT])) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- INTCON
  // Write first, then GIE handshake override, then hardware flag sets so a
  // same-cycle hardware event always survives a software clear.
  always_comb begin
    intcon_next = intcon_we ? intcon_wdata : intcon;
    if (ack_take)    intcon_next[GIE_BIT] = 1'b0;
    else if (retfie) intcon_next[GIE_BIT] = 1'b1;
    if (t0_set)  intcon_next[T0IF_BIT] = 1'b1;
    if (int_set) intcon_next[INTF_BIT] = 1'b1;
    if (rb_set)  intcon_next[RBIF_BIT] = 1'b1;
  end

  always_ff @(posedge oscIn or negedge reset) begin
    if (!reset) begin
      intcon  <= INTCON_RST;
      t0if_q  <= 1'b0;
      ee_pend <= 1'b0;
      rb_snap <= '0;
      irq_req <= 1'b0;
      wake    <= 1'b0;
    end else begin
      intcon  <= intcon_next;
      t0if_q  <= t0if;
      ee_pend <= eeif | (ee_pend & ~ack_take);
      if (portb_rd) rb_snap <= rb_sync;
      irq_req <= (state_next == ST_REQ);
      wake    <= pend;
    end
  end

  assign intcon_rdata = intcon;

endmodule

// File: tb/tb_intcon_ctrl.sv
module tb_intcon_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       t0if, eeif, rb0_pin, intedg, portb_rd, intcon_we, irq_ack, retfie;
  logic [3:0] rb_hi_pin, rb_hi_tris;
  logic [7:0] intcon_wdata, intcon_rdata;
  logic       irq_req, wake;

  int pass_cnt = 0;
  int total_cnt = 0;

  intcon_ctrl #(.SYNC_STAGES(2), .INTCON_RST(8'h00)) dut (
    .oscIn        (clk),
    .reset        (reset),
    .t0if         (t0if),
    .eeif         (eeif),
    .rb0_pin      (rb0_pin),
    .intedg       (intedg),
    .rb_hi_pin    (rb_hi_pin),
    .rb_hi_tris   (rb_hi_tris),
    .portb_rd     (portb_rd),
    .intcon_we    (intcon_we),
    .intcon_wdata (intcon_wdata),
    .intcon_rdata (intcon_rdata),
    .irq_req      (irq_req),
    .irq_ack      (irq_ack),
    .retfie       (retfie),
    .wake         (wake)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] wdata;
    logic       t0;
    logic       ack;
    logic       rfi;
    logic       ee;
    logic [7:0] exp_ic;
    logic       exp_req;
    logic       exp_wake;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic t0,
                              input logic ack, input logic rfi, input logic ee,
                              input logic [7:0] ic, input logic rq, input logic wk);
    vec_t v;
    v.we = we; v.wdata = wd; v.t0 = t0; v.ack = ack; v.rfi = rfi; v.ee = ee;
    v.exp_ic = ic; v.exp_req = rq; v.exp_wake = wk;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    t0if = 0; eeif = 0; portb_rd = 0; intcon_we = 0; intcon_wdata = 8'h00;
    irq_ack = 0; retfie = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rb0_pin = 0; intedg = 1; rb_hi_pin = 4'h0; rb_hi_tris = 4'h0;
    reset = 0;
    step(); step();
    reset = 1;
  endtask

  task automatic write_intcon(input logic [7:0] d);
    intcon_we = 1; intcon_wdata = d;
    step();
    intcon_we = 0;
  endtask

  initial begin
    // handshake / flag table, one row per clock
    vecs[0]  = mk(1, 8'hA0, 0, 0, 0, 0, 8'hA0, 0, 0);
    vecs[1]  = mk(0, 8'h00, 1, 0, 0, 0, 8'hA4, 0, 0);
    vecs[2]  = mk(0, 8'h00, 0, 0, 0, 0, 8'hA4, 1, 1);
    vecs[3]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h24, 0, 1);
    vecs[4]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h24, 0, 1);
    vecs[5]  = mk(0, 8'h00, 0, 0, 1, 0, 8'hA4, 0, 1);
    vecs[6]  = mk(0, 8'h00, 0, 0, 0, 0, 8'hA4, 1, 1);
    vecs[7]  = mk(1, 8'h20, 0, 0, 0, 0, 8'h20, 1, 1);
    vecs[8]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h20, 0, 0);
    vecs[9]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h20, 0, 0);
    vecs[10] = mk(0, 8'h00, 0, 0, 0, 0, 8'h20, 0, 0);
    vecs[11] = mk(1, 8'h20, 1, 0, 0, 0, 8'h24, 0, 0);
    vecs[12] = mk(0, 8'h00, 0, 0, 0, 0, 8'h24, 0, 1);
    vecs[13] = mk(0, 8'h00, 0, 0, 0, 0, 8'h24, 0, 1);
    vecs[14] = mk(1, 8'hA4, 0, 0, 0, 0, 8'hA4, 0, 1);
    vecs[15] = mk(0, 8'h00, 0, 0, 0, 0, 8'hA4, 1, 1);
    vecs[16] = mk(1, 8'hE4, 0, 1, 0, 0, 8'h64, 0, 1);
    vecs[17] = mk(1, 8'hA4, 0, 0, 0, 0, 8'hA4, 0, 1);
    vecs[18] = mk(0, 8'h00, 0, 0, 0, 0, 8'hA4, 1, 1);
    vecs[19] = mk(0, 8'h00, 0, 1, 0, 0, 8'h24, 0, 1);
    vecs[20] = mk(1, 8'h40, 0, 0, 0, 0, 8'h40, 0, 1);
    vecs[21] = mk(0, 8'h00, 0, 0, 0, 1, 8'h40, 0, 0);
    vecs[22] = mk(1, 8'h40, 0, 0, 0, 0, 8'h40, 0, 1);
    vecs[23] = mk(1, 8'hC0, 0, 0, 0, 0, 8'hC0, 0, 1);
    vecs[24] = mk(0, 8'h00, 0, 0, 0, 0, 8'hC0, 1, 1);
    vecs[25] = mk(0, 8'h00, 0, 1, 0, 0, 8'h40, 0, 1);
    vecs[26] = mk(0, 8'h00, 0, 0, 0, 0, 8'h40, 0, 0);
    vecs[27] = mk(0, 8'h00, 0, 0, 1, 0, 8'hC0, 0, 0);
    vecs[28] = mk(0, 8'h00, 0, 0, 0, 0, 8'hC0, 0, 0);
    vecs[29] = mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    vecs[30] = mk(0, 8'h00, 0, 0, 1, 0, 8'h80, 0, 0);
    vecs[31] = mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);

    do_reset();
    check("reset_intcon", intcon_rdata, 8'h00);
    check("reset_irq_req", {7'd0, irq_req}, 8'h00);
    check("reset_wake", {7'd0, wake}, 8'h00);

    for (int i = 0; i < 32; i++) begin
      intcon_we = vecs[i].we; intcon_wdata = vecs[i].wdata; t0if = vecs[i].t0;
      irq_ack = vecs[i].ack; retfie = vecs[i].rfi; eeif = vecs[i].ee;
      step();
      check($sformatf("row%0d_intcon", i), intcon_rdata, vecs[i].exp_ic);
      check($sformatf("row%0d_irq_req", i), {7'd0, irq_req}, {7'd0, vecs[i].exp_req});
      check($sformatf("row%0d_wake", i), {7'd0, wake}, {7'd0, vecs[i].exp_wake});
    end
    idle_inputs();

    // RB0/INT edge, falling polarity
    do_reset();
    intedg = 0;
    write_intcon(8'h90);
    rb0_pin = 1;
    repeat (5) step();
    check("rb0_rise_ignored", intcon_rdata, 8'h90);
    intedg = 1;
    repeat (3) step();
    check("intedg_change_no_edge", intcon_rdata, 8'h90);
    intedg = 0;
    step();
    rb0_pin = 0;
    step();
    check("rb0_fall_edge1", intcon_rdata, 8'h90);
    step();
    check("rb0_fall_edge2", intcon_rdata, 8'h90);
    step();
    check("rb0_fall_edge3_intf", intcon_rdata, 8'h92);
    step();
    check("rb0_irq_req", {7'd0, irq_req}, 8'h01);

    // RB7:4 change
    do_reset();
    rb_hi_tris = 4'hF;
    rb_hi_pin = 4'hA;
    repeat (4) step();
    portb_rd = 1;
    step();
    portb_rd = 0;
    write_intcon(8'h88);
    check("rb_snap_clears", intcon_rdata, 8'h88);
    step();
    check("rb_no_mismatch", intcon_rdata, 8'h88);
    rb_hi_pin = 4'hB;
    step();
    check("rb_change_c1", intcon_rdata, 8'h88);
    step();
    check("rb_change_c2", intcon_rdata, 8'h88);
    step();
    check("rb_change_c3_rbif", intcon_rdata, 8'h89);
    write_intcon(8'h08);
    check("rb_clear_write_cycle", {7'd0, intcon_rdata[0]}, 8'h01);
    step();
    check("rb_clear_reset_rbif", {7'd0, intcon_rdata[0]}, 8'h01);

    // tris masking
    do_reset();
    rb_hi_pin = 4'hB;
    repeat (4) step();
    check("rb_tris_masked", intcon_rdata, 8'h00);
    rb_hi_tris = 4'h1;
    step();
    check("rb_tris_bit0", intcon_rdata, 8'h01);

    // asynchronous reset inside ISR
    do_reset();
    write_intcon(8'hA0);
    t0if = 1;
    step();
    t0if = 0;
    step();
    check("isr_entry_req", {7'd0, irq_req}, 8'h01);
    irq_ack = 1;
    step();
    irq_ack = 0;
    check("isr_entry_intcon", intcon_rdata, 8'h24);
    check("isr_wake", {7'd0, wake}, 8'h01);
    #3;
    reset = 0;
    #1;
    check("async_reset_intcon", intcon_rdata, 8'h00);
    check("async_reset_irq_req", {7'd0, irq_req}, 8'h00);
    check("async_reset_wake", {7'd0, wake}, 8'h00);
    step();
    reset = 1;
    step();
    check("post_reset_idle", {7'd0, irq_req}, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
